// File: rtl/decode_stage_ctl.sv
// RV32 decode stage with ID/EX pipeline register, register file, WB->ID bypass and illegal-opcode flag.
// Optional build macro DECODE_UTYPE_EN enables LUI/AUIPC decode and the alu_a_pc_e output.
module decode_stage_ctl #(
    parameter int               XLEN   = 32,
    parameter int               NREG   = 32,
    parameter logic [XLEN-1:0]  RST_PC = '0,
    localparam int              RW     = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_d,
    input  logic            flush_e,
    input  logic [31:0]     instr_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] pc_plus4_d,
    input  logic            reg_write_w,
    input  logic [RW-1:0]   rd_w,
    input  logic [XLEN-1:0] result_w,
    output logic            valid_e,
    output logic            reg_write_e,
    output logic            alu_src_e,
    output logic            mem_write_e,
    output logic [1:0]      result_src_e,
    output logic            branch_e,
    output logic            jump_e,
    output logic [2:0]      alu_control_e,
    output logic            illegal_e,
    output logic [XLEN-1:0] rd1_e,
    output logic [XLEN-1:0] rd2_e,
    output logic [XLEN-1:0] imm_ext_e,
    output logic [RW-1:0]   rs1_e,
    output logic [RW-1:0]   rs2_e,
    output logic [RW-1:0]   rd_e,
    output logic [XLEN-1:0] pc_e,
    output logic [XLEN-1:0] pc_plus4_e
`ifdef DECODE_UTYPE_EN
    ,
    output logic            alu_a_pc_e
`endif
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
`ifdef DECODE_UTYPE_EN
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
`endif

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            alu_src;
        logic            mem_write;
        logic [1:0]      result_src;
        logic            branch;
        logic            jump;
        logic [2:0]      alu_control;
        logic            illegal;
`ifdef DECODE_UTYPE_EN
        logic            alu_a_pc;
`endif
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm_ext;
        logic [RW-1:0]   rs1;
        logic [RW-1:0]   rs2;
        logic [RW-1:0]   rd;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } id_ex_t;

    logic [XLEN-1:0] regs [NREG];
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [RW-1:0]   rs1_d, rs2_d, rd_d;
    logic [XLEN-1:0] rd1_d, rd2_d;
    logic [31:0]     imm_i, imm_s, imm_b, imm_j;
    logic [31:0]     imm32;
    id_ex_t          ex_d, ex_q;

    assign opcode = instr_d[6:0];
    assign funct3 = instr_d[14:12];
    assign imm_i  = {{20{instr_d[31]}}, instr_d[31:20]};
    assign imm_s  = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
    assign imm_b  = {{20{instr_d[31]}}, instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0};
    assign imm_j  = {{12{instr_d[31]}}, instr_d[19:12], instr_d[20], instr_d[30:21], 1'b0};

    // LUI has no rs1 field, so its export is forced to x0 to keep the hazard unit quiet
`ifdef DECODE_UTYPE_EN
    assign rs1_d = (opcode == OP_LUI) ? '0 : RW'(instr_d[19:15]);
`else
    assign rs1_d = RW'(instr_d[19:15]);
`endif
    assign rs2_d = RW'(instr_d[24:20]);
    assign rd_d  = RW'(instr_d[11:7]);

    function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  alu_op = sub ? 3'b001 : 3'b000;
            3'b010:  alu_op = 3'b101;
            3'b110:  alu_op = 3'b011;
            3'b111:  alu_op = 3'b010;
            default: alu_op = 3'b000;
        endcase
    endfunction

    // Register read with same-cycle write-back bypass; x0 and out-of-range indices read 0
    always_comb begin
        rd1_d = '0;
        rd2_d = '0;
        if (rs1_d != '0 && int'(rs1_d) < NREG)
            rd1_d = (reg_write_w && rd_w == rs1_d) ? result_w : regs[rs1_d];
        if (rs2_d != '0 && int'(rs2_d) < NREG)
            rd2_d = (reg_write_w && rd_w == rs2_d) ? result_w : regs[rs2_d];
    end

    always_comb begin
        ex_d          = '0;
        imm32         = '0;
        ex_d.valid    = 1'b1;
        ex_d.rd1      = rd1_d;
        ex_d.rd2      = rd2_d;
        ex_d.rs1      = rs1_d;
        ex_d.rs2      = rs2_d;
        ex_d.rd       = rd_d;
        ex_d.pc       = pc_d;
        ex_d.pc_plus4 = pc_plus4_d;
        case (opcode)
            OP_R: begin
                ex_d.reg_write   = 1'b1;
                ex_d.alu_control = alu_op(funct3, instr_d[30]);
            end
            OP_I: begin
                ex_d.reg_write   = 1'b1;
                ex_d.alu_src     = 1'b1;
                ex_d.alu_control = alu_op(funct3, 1'b0);
                imm32            = imm_i;
            end
            OP_LW: begin
                ex_d.reg_write  = 1'b1;
                ex_d.alu_src    = 1'b1;
                ex_d.result_src = 2'b01;
                imm32           = imm_i;
            end
            OP_SW: begin
                ex_d.mem_write = 1'b1;
                ex_d.alu_src   = 1'b1;
                imm32          = imm_s;
            end
            OP_BEQ: begin
                ex_d.branch      = 1'b1;
                ex_d.alu_control = 3'b001;
                imm32            = imm_b;
            end
            OP_JAL: begin
                ex_d.reg_write  = 1'b1;
                ex_d.jump       = 1'b1;
                ex_d.result_src = 2'b10;
                imm32           = imm_j;
            end
`ifdef DECODE_UTYPE_EN
            OP_LUI, OP_AUIPC: begin
                ex_d.reg_write = 1'b1;
                ex_d.alu_src   = 1'b1;
                ex_d.alu_a_pc  = (opcode == OP_AUIPC);
                imm32          = {instr_d[31:12], 12'b0};
            end
`endif
            default: ex_d.illegal = 1'b1;
        endcase
        ex_d.imm_ext = XLEN'(signed'(imm32));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (reg_write_w && rd_w != '0 && int'(rd_w) < NREG) begin
            regs[rd_w] <= result_w;
        end
    end

    // A flush loads the same bubble as reset but leaves the register file alone
    always_ff @(posedge clk) begin
        if (rst || flush_e) begin
            ex_q          <= '0;
            ex_q.pc       <= RST_PC;
            ex_q.pc_plus4 <= RST_PC;
        end else if (!stall_d) begin
            ex_q <= ex_d;
        end
    end

    assign valid_e       = ex_q.valid;
    assign reg_write_e   = ex_q.reg_write;
    assign alu_src_e     = ex_q.alu_src;
    assign mem_write_e   = ex_q.mem_write;
    assign result_src_e  = ex_q.result_src;
    assign branch_e      = ex_q.branch;
    assign jump_e        = ex_q.jump;
    assign alu_control_e = ex_q.alu_control;
    assign illegal_e     = ex_q.illegal;
    assign rd1_e         = ex_q.rd1;
    assign rd2_e         = ex_q.rd2;
    assign imm_ext_e     = ex_q.imm_ext;
    assign rs1_e         = ex_q.rs1;
    assign rs2_e         = ex_q.rs2;
    assign rd_e          = ex_q.rd;
    assign pc_e          = ex_q.pc;
    assign pc_plus4_e    = ex_q.pc_plus4;
`ifdef DECODE_UTYPE_EN
    assign alu_a_pc_e    = ex_q.alu_a_pc;
`endif

endmodule
